// File: rtl/led_pwm_driver.sv
// Per-LED PWM brightness driver with a double-buffered level word that is applied only at PWM period boundaries.
// Optional blink gating is compiled in when LED_PWM_BLINK_EN is defined; the default build is pure PWM.
module led_pwm_driver #(
    parameter int NUM_LEDS      = 8,
    parameter int LEVEL_BITS    = 4,
    parameter int PRESCALE      = 16,
    parameter int BLINK_PERIODS = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_wr_stb,
    input  logic [NUM_LEDS*LEVEL_BITS-1:0] i_wr_data,
`ifdef LED_PWM_BLINK_EN
    input  logic [NUM_LEDS-1:0]            i_blink_mask,
`endif
    output logic [NUM_LEDS-1:0]            o_led,
    output logic                           o_pending,
    output logic                           o_period_stb
);

    localparam int MAX   = 2**LEVEL_BITS - 1;
    localparam int DW    = NUM_LEDS * LEVEL_BITS;
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CNT_W = (MAX > 1) ? $clog2(MAX) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX - 1);

    if (PRESCALE < 1 || BLINK_PERIODS < 1) begin : g_bad_params
        $error("led_pwm_driver: PRESCALE and BLINK_PERIODS must be >= 1");
    end

    logic [PS_W-1:0]     presc, presc_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                tick, boundary, stb_nxt;
    logic [DW-1:0]       shadow, active;
    logic [NUM_LEDS-1:0] pwm, led_nxt;

    always_comb begin
        tick      = (presc == PS_LAST);
        boundary  = tick && (cnt == CNT_LAST);
        presc_nxt = tick ? '0 : presc + 1'b1;
        cnt_nxt   = cnt;
        if (tick) begin
            cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        // NOTE: the strobe is registered from the next-state counters so it is high
        // during the boundary cycle itself, letting a write aligned to it land immediately.
        stb_nxt = (presc_nxt == PS_LAST) && (cnt_nxt == CNT_LAST);
        for (int k = 0; k < NUM_LEDS; k++) begin
            pwm[k] = active[k*LEVEL_BITS +: LEVEL_BITS] > LEVEL_BITS'(cnt);
        end
    end

`ifdef LED_PWM_BLINK_EN
    localparam int BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_PERIODS - 1);

    logic [BL_W-1:0] blink_cnt;
    logic            blink_on;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (boundary) begin
            if (blink_cnt == BL_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        led_nxt = pwm & ~(i_blink_mask & {NUM_LEDS{~blink_on}});
    end
`else
    always_comb begin
        led_nxt = pwm;
    end
`endif

    // NOTE: every register, including the level buffers, is cleared by reset so a
    // write pending at reset time can never surface afterwards.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            presc        <= '0;
            cnt          <= '0;
            shadow       <= '0;
            active       <= '0;
            o_led        <= '0;
            o_pending    <= 1'b0;
            o_period_stb <= 1'b0;
        end else begin
            presc        <= presc_nxt;
            cnt          <= cnt_nxt;
            o_period_stb <= stb_nxt;
            o_led        <= led_nxt;
            if (i_wr_stb) begin
                shadow <= i_wr_data;
            end
            // A write coinciding with the boundary bypasses the shadow entirely.
            if (boundary && (o_pending || i_wr_stb)) begin
                active    <= i_wr_stb ? i_wr_data : shadow;
                o_pending <= 1'b0;
            end else if (i_wr_stb) begin
                o_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed testbench for led_pwm_driver (NUM_LEDS=8, LEVEL_BITS=4, PRESCALE=2 -> 30-cycle period).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_led_pwm_driver;

    localparam int NL  = 8;
    localparam int LB  = 4;
    localparam int PS  = 2;
    localparam int PER = 15 * PS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_stb;
    logic [31:0]   wr_data;
    logic [NL-1:0] led;
    logic          pending;
    logic          period_stb;
`ifdef LED_PWM_BLINK_EN
    logic [NL-1:0] blink_mask;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [NL-1:0] samp [PER];
    int            stb_seen;

    always #5 clk = ~clk;

    led_pwm_driver #(
        .NUM_LEDS      (NL),
        .LEVEL_BITS    (LB),
        .PRESCALE      (PS),
        .BLINK_PERIODS (2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_wr_stb     (wr_stb),
        .i_wr_data    (wr_data),
`ifdef LED_PWM_BLINK_EN
        .i_blink_mask (blink_mask),
`endif
        .o_led        (led),
        .o_pending    (pending),
        .o_period_stb (period_stb)
    );

    // LED k is on for level*PS cycles at the start of each 30-cycle period.
    function automatic logic [NL-1:0] pwm_exp(input logic [31:0] levels, input int phase);
        logic [NL-1:0] e;
        for (int k = 0; k < NL; k++) begin
            e[k] = (int'(levels[k*LB +: LB]) * PS) > phase;
        end
        return e;
    endfunction

    task automatic wait_boundary(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (period_stb === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic capture_period();
        stb_seen = 0;
        for (int i = 0; i < PER; i++) begin
            @(negedge clk);
            samp[i] = led;
            if (period_stb === 1'b1) stb_seen++;
        end
    endtask

    task automatic test_reset();
        int k;
        rst_n   = 1'b0;
        wr_stb  = 1'b1;
        wr_data = 32'hFFFF_FFFF;
        repeat (5) @(negedge clk);
        cmp_cnt++;
        if ({led, pending, period_stb} !== 10'b0) begin
            err_cnt++;
            $display("FAIL reset_outputs: led=%h pending=%b stb=%b expected all 0", led, pending, period_stb);
        end
        rst_n = 1'b1;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                wr_stb = 1'b0;
                cmp_cnt++;
                if (pending !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL post_reset_pending: pending=%b expected 1", pending);
                end
            end
            if (period_stb === 1'b1) break;
        end
        cmp_cnt++;
        if (k != PER - 1) begin
            err_cnt++;
            $display("FAIL first_boundary: stb after %0d cycles expected %0d", k, PER - 1);
        end
        @(negedge clk);
        cmp_cnt++;
        if (led !== 8'h00) begin
            err_cnt++;
            $display("FAIL first_period_led: led=%h expected 00", led);
        end
        @(negedge clk);
        cmp_cnt++;
        if (led !== 8'hFF) begin
            err_cnt++;
            $display("FAIL write_after_reset: led=%h expected ff", led);
        end
    endtask

    localparam logic [31:0] DUTY_LV = 32'h0000_F710;

    task automatic test_duty();
        bit ok;
        int hi [4];
        int exp_hi [4] = '{0, 2, 14, 30};
        logic [NL-1:0] e;
        wr_stb  = 1'b1;
        wr_data = DUTY_LV;
        @(negedge clk);
        wr_stb = 1'b0;
        wait_boundary(ok);
        cmp_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL duty_boundary: no o_period_stb within 200 cycles");
        end
        @(negedge clk);
        capture_period();
        hi = '{0, 0, 0, 0};
        for (int i = 0; i < PER; i++) begin
            e = pwm_exp(DUTY_LV, i);
            cmp_cnt++;
            if (samp[i] !== e) begin
                err_cnt++;
                $display("FAIL duty_phase_%0d: led=%h expected %h", i, samp[i], e);
            end
            for (int j = 0; j < 4; j++) if (samp[i][j] === 1'b1) hi[j]++;
        end
        for (int j = 0; j < 4; j++) begin
            cmp_cnt++;
            if (hi[j] != exp_hi[j]) begin
                err_cnt++;
                $display("FAIL duty_led%0d_high: %0d cycles expected %0d", j, hi[j], exp_hi[j]);
            end
        end
        cmp_cnt++;
        if (stb_seen != 1) begin
            err_cnt++;
            $display("FAIL duty_stb_count: %0d per period expected 1", stb_seen);
        end
    endtask

    task automatic test_double_buffer();
        bit ok;
        logic [NL-1:0] e;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            e = pwm_exp(DUTY_LV, i);
            cmp_cnt++;
            if (led !== e || pending !== (i >= 6)) begin
                err_cnt++;
                $display("FAIL dbuf_pre_phase_%0d: led=%h pending=%b expected %h %b", i, led, pending, e, (i >= 6));
            end
            wr_stb = (i == 5) || (i == 10);
            wr_data = (i == 5) ? 32'h8888_8888 : 32'h3333_3333;
        end
        wait_boundary(ok);
        cmp_cnt++;
        if (!ok || pending !== 1'b1) begin
            err_cnt++;
            $display("FAIL dbuf_boundary: found=%b pending=%b expected 1 1", ok, pending);
        end
        @(negedge clk);
        cmp_cnt++;
        if (pending !== 1'b0) begin
            err_cnt++;
            $display("FAIL dbuf_pending_clear: pending=%b expected 0", pending);
        end
        capture_period();
        for (int i = 0; i < PER; i++) begin
            e = pwm_exp(32'h3333_3333, i);
            cmp_cnt++;
            if (samp[i] !== e) begin
                err_cnt++;
                $display("FAIL dbuf_phase_%0d: led=%h expected %h", i, samp[i], e);
            end
        end
    endtask

    localparam logic [31:0] BW_LV = 32'hFEDC_5421;

    task automatic test_boundary_write();
        bit ok;
        logic [NL-1:0] e;
        wait_boundary(ok);
        cmp_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL bwr_boundary: no o_period_stb within 200 cycles");
        end
        wr_stb  = 1'b1;
        wr_data = BW_LV;
        @(negedge clk);
        wr_stb = 1'b0;
        cmp_cnt++;
        if (pending !== 1'b0) begin
            err_cnt++;
            $display("FAIL bwr_pending: pending=%b expected 0", pending);
        end
        capture_period();
        for (int i = 0; i < PER; i++) begin
            e = pwm_exp(BW_LV, i);
            cmp_cnt++;
            if (samp[i] !== e) begin
                err_cnt++;
                $display("FAIL bwr_phase_%0d: led=%h expected %h", i, samp[i], e);
            end
        end
        cmp_cnt++;
        if (stb_seen != 1 || pending !== 1'b0) begin
            err_cnt++;
            $display("FAIL bwr_end: stb_count=%0d pending=%b expected 1 0", stb_seen, pending);
        end
    endtask

    task automatic test_reset_mid();
        repeat (7) @(negedge clk);
        wr_stb  = 1'b1;
        wr_data = 32'h8888_8888;
        @(negedge clk);
        wr_stb = 1'b0;
        cmp_cnt++;
        if (pending !== 1'b1) begin
            err_cnt++;
            $display("FAIL rmid_pending_before: pending=%b expected 1", pending);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cmp_cnt++;
        if ({led, pending, period_stb} !== 10'b0) begin
            err_cnt++;
            $display("FAIL rmid_reset: led=%h pending=%b stb=%b expected all 0", led, pending, period_stb);
        end
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if (led !== 8'h00 || pending !== 1'b0) begin
                err_cnt++;
                $display("FAIL rmid_cycle_%0d: led=%h pending=%b expected 00 0", i, led, pending);
            end
        end
    endtask

`ifdef LED_PWM_BLINK_EN
    task automatic test_blink();
        bit ok;
        logic [NL-1:0] exp_per [6] = '{8'hFF, 8'hF0, 8'hF0, 8'hFF, 8'hFF, 8'hF0};
        blink_mask = 8'h0F;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        wr_stb  = 1'b1;
        wr_data = 32'hFFFF_FFFF;
        @(negedge clk);
        wr_stb = 1'b0;
        wait_boundary(ok);
        cmp_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL blink_boundary: no o_period_stb within 200 cycles");
        end
        @(negedge clk);
        for (int p = 0; p < 6; p++) begin
            capture_period();
            for (int i = 0; i < PER; i++) begin
                cmp_cnt++;
                if (samp[i] !== exp_per[p]) begin
                    err_cnt++;
                    $display("FAIL blink_period%0d_phase_%0d: led=%h expected %h", p + 1, i, samp[i], exp_per[p]);
                end
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        wr_stb  = 1'b0;
        wr_data = '0;
`ifdef LED_PWM_BLINK_EN
        blink_mask = '0;
`endif
        test_reset();
        test_duty();
        test_double_buffer();
        test_boundary_write();
        test_reset_mid();
`ifdef LED_PWM_BLINK_EN
        test_blink();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
